store_buffer: RTL and testbench

- Sits directly upstream of the word-addressed data memory `Datmem` in the 32-bit processor MEM stage.
- Accepts stores from the execute stage into a DEPTH-entry FIFO, then drains them one at a time to `Datmem` using a two-cycle setup/write sequence on `WE2`.
- Services loads by driving `Datmem` `Addr` and returning `ReaDat`, with store-to-load forwarding from buffered entries.

---
 rtl/sb_pkg.sv | 26 ++
 rtl/sb_fifo.sv | 72 +++++++
 rtl/store_buffer.sv | 168 ++++++++++++++++
 tb/tb_store_buffer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sb_pkg.sv
// Shared types for the store buffer: FSM states, FIFO entry layout and pointer sizing.
package sb_pkg;

  localparam int unsigned SbWidth = 32;
  localparam int unsigned SbDepth = 4;
  localparam int unsigned SbPtrW  = $clog2(SbDepth);
  localparam int unsigned SbCntW  = SbPtrW + 1;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StWrite,
    StLdAddr,
    StLdData
  } sb_state_t;

  typedef struct packed {
    logic [SbWidth-1:0] addr;
    logic [SbWidth-1:0] data;
  } sb_entry_t;

  function automatic int unsigned sb_ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sb_fifo.sv
// Store buffer entry storage: circular FIFO of {addr, data} with a
// combinational youngest-match lookup for store-to-load forwarding.
module sb_fifo
  import sb_pkg::*;
#(
  parameter int unsigned DEPTH = SbDepth
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  sb_entry_t                push_entry,
  input  logic                     pop,
  output sb_entry_t                head,
  output sb_entry_t                second,
  output logic [sb_ptr_w(DEPTH):0] count,
  output logic                     full,
  output logic                     empty,
  input  logic [SbWidth-1:0]       lookup_addr,
  output logic                     fwd_hit,
  output logic [SbWidth-1:0]       fwd_data
);

  localparam int unsigned PtrW = sb_ptr_w(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  sb_entry_t       mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [PtrW-1:0] rd_nxt;
  logic [PtrW-1:0] idx;
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
    end
  end

  // Payload needs no reset; validity is carried by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

  assign rd_nxt = rd_ptr_q + 1'b1;
  assign head   = mem_q[rd_ptr_q];
  assign second = mem_q[rd_nxt];
  assign count  = cnt_q;
  assign full   = (cnt_q == CntW'(DEPTH));
  assign empty  = (cnt_q == '0);

  // Walk oldest to youngest so the last hit is the youngest store.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PtrW'(i);
      if ((CntW'(i) < cnt_q) && (mem_q[idx].addr == lookup_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = mem_q[idx].data;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Store buffer in front of Datmem: queues stores, drains them with a
// setup/write sequence on WE2, and services loads with store forwarding.
module store_buffer
  import sb_pkg::*;
#(
  parameter int unsigned AWIDTH  = 32,
  parameter int unsigned ALENGTH = 128,
  parameter int unsigned DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              StoreReq,
  input  logic              LoadReq,
  input  logic [AWIDTH-1:0] ReqAddr,
  input  logic [AWIDTH-1:0] StoreDat,
  output logic              Stall,
  output logic [AWIDTH-1:0] LoadDat,
  output logic              LoadVld,
  output logic              AddrErr,
  output logic [AWIDTH-1:0] Addr,
  output logic [AWIDTH-1:0] WriDat,
  output logic              WE2,
  input  logic [AWIDTH-1:0] ReaDat,
  output logic              Full,
  output logic              Empty
);

  localparam int unsigned PtrW = sb_ptr_w(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  sb_state_t         state_q;
  logic              ld_hold_q;
  logic [AWIDTH-1:0] ld_addr_q;
  logic              fwd_hit_q;
  logic [AWIDTH-1:0] fwd_data_q;

  sb_entry_t         push_entry;
  sb_entry_t         head;
  sb_entry_t         second;
  sb_entry_t         nxt_head;
  logic [CntW-1:0]   count;
  logic              fwd_hit;
  logic [AWIDTH-1:0] fwd_data;

  logic in_load;
  logic pop;
  logic load_acc;
  logic store_acc;
  logic addr_oob;
  logic remain;

  assign push_entry.addr = ReqAddr;
  assign push_entry.data = StoreDat;

  sb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (store_acc),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .second     (second),
    .count      (count),
    .full       (Full),
    .empty      (Empty),
    .lookup_addr(ReqAddr),
    .fwd_hit    (fwd_hit),
    .fwd_data   (fwd_data)
  );

  assign in_load   = (state_q == StLdAddr) || (state_q == StLdData);
  assign pop       = (state_q == StWrite);
  assign load_acc  = LoadReq && !in_load;
  assign store_acc = StoreReq && !LoadReq && (!Full || pop);
  assign addr_oob  = (ReqAddr >= AWIDTH'(ALENGTH));

  assign Stall = (StoreReq && LoadReq) ||
                 (StoreReq && Full && !pop) ||
                 (LoadReq && in_load);

  // After a pop the next head is the second entry, or the store landing now.
  assign remain   = (count > CntW'(1)) || store_acc;
  assign nxt_head = (count > CntW'(1)) ? second : push_entry;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      ld_hold_q  <= 1'b0;
      ld_addr_q  <= '0;
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
      Addr       <= '0;
      WriDat     <= '0;
      WE2        <= 1'b0;
      LoadDat    <= '0;
      LoadVld    <= 1'b0;
      AddrErr    <= 1'b0;
    end else begin
      WE2     <= 1'b0;
      LoadVld <= 1'b0;
      AddrErr <= (load_acc || store_acc) && addr_oob;

      if (load_acc) begin
        ld_addr_q  <= ReqAddr;
        fwd_hit_q  <= fwd_hit;
        fwd_data_q <= fwd_data;
      end

      unique case (state_q)
        StIdle: begin
          if (load_acc) begin
            state_q <= StLdAddr;
            Addr    <= ReqAddr;
          end else if (!Empty) begin
            state_q <= StSetup;
            Addr    <= head.addr;
            WriDat  <= head.data;
          end
        end
        StSetup: begin
          if (load_acc) begin
            state_q <= StLdAddr;
            Addr    <= ReqAddr;
          end else begin
            state_q <= StWrite;
            WE2     <= 1'b1;
          end
        end
        StWrite: begin
          // Keep the written address on Datmem one extra cycle before a load.
          if (load_acc) begin
            state_q   <= StLdAddr;
            ld_hold_q <= 1'b1;
          end else if (remain) begin
            state_q <= StSetup;
            Addr    <= nxt_head.addr;
            WriDat  <= nxt_head.data;
          end else begin
            state_q <= StIdle;
          end
        end
        StLdAddr: begin
          if (ld_hold_q) begin
            ld_hold_q <= 1'b0;
            Addr      <= ld_addr_q;
          end else begin
            state_q <= StLdData;
            LoadDat <= fwd_hit_q ? fwd_data_q : ReaDat;
            LoadVld <= 1'b1;
          end
        end
        StLdData: begin
          if (!Empty) begin
            state_q <= StSetup;
            Addr    <= head.addr;
            WriDat  <= head.data;
          end else begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a behavioural 128-word Datmem model.
module tb_store_buffer;

  logic        clk;
  logic        rst;
  logic        StoreReq;
  logic        LoadReq;
  logic [31:0] ReqAddr;
  logic [31:0] StoreDat;
  logic        Stall;
  logic [31:0] LoadDat;
  logic        LoadVld;
  logic        AddrErr;
  logic [31:0] Addr;
  logic [31:0] WriDat;
  logic        WE2;
  logic [31:0] ReaDat;
  logic        Full;
  logic        Empty;

  logic [31:0] mem [128];
  bit          written [128];
  logic [31:0] wr_log [64];
  int          wr_cnt;
  int          checks;
  int          errors;
  int          wc;

  store_buffer #(
    .AWIDTH (32),
    .ALENGTH(128),
    .DEPTH  (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .StoreReq(StoreReq),
    .LoadReq (LoadReq),
    .ReqAddr (ReqAddr),
    .StoreDat(StoreDat),
    .Stall   (Stall),
    .LoadDat (LoadDat),
    .LoadVld (LoadVld),
    .AddrErr (AddrErr),
    .Addr    (Addr),
    .WriDat  (WriDat),
    .WE2     (WE2),
    .ReaDat  (ReaDat),
    .Full    (Full),
    .Empty   (Empty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Unwritten words read back as 0xD000 + address.
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return written[a[6:0]] ? mem[a[6:0]] : (32'hD000 + {25'b0, a[6:0]});
  endfunction

  assign ReaDat = (Addr < 32'd128) ? mem_rd(Addr) : 32'h0;

  always @(posedge clk) begin
    if (WE2 && (Addr < 32'd128)) begin
      mem[Addr[6:0]]     <= WriDat;
      written[Addr[6:0]] <= 1'b1;
      wr_log[wr_cnt[5:0]] <= Addr;
      wr_cnt             <= wr_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic l, input logic [31:0] a, input logic [31:0] d);
    StoreReq = s;
    LoadReq  = l;
    ReqAddr  = a;
    StoreDat = d;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_empty(input string tag);
    for (int i = 0; i < 50; i++) begin
      if (Empty) break;
      tick();
    end
    check(tag, {31'b0, Empty}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    StoreReq = 1'b0;
    LoadReq = 1'b0;
    ReqAddr = '0;
    StoreDat = '0;
    #1 rst = 1'b1;
    #2;
    check("rst_we2", {31'b0, WE2}, 0);
    check("rst_empty", {31'b0, Empty}, 1);
    check("rst_full", {31'b0, Full}, 0);
    check("rst_addr", Addr, 0);
    check("rst_wridat", WriDat, 0);
    check("rst_loadvld", {31'b0, LoadVld}, 0);
    check("rst_loaddat", LoadDat, 0);
    check("rst_addrerr", {31'b0, AddrErr}, 0);
    tick();
    rst = 1'b0;

    // Single store to the last valid word, then read it back.
    drive(1'b1, 1'b0, 32'h7F, 32'h6000);
    check("st_stall", {31'b0, Stall}, 0);
    tick(); idle();
    check("st_not_empty", {31'b0, Empty}, 0);
    check("st_no_addrerr", {31'b0, AddrErr}, 0);
    tick();
    check("st_setup_addr", Addr, 32'h7F);
    check("st_setup_dat", WriDat, 32'h6000);
    check("st_setup_we2", {31'b0, WE2}, 0);
    tick();
    check("st_write_we2", {31'b0, WE2}, 1);
    check("st_write_addr", Addr, 32'h7F);
    tick();
    check("st_done_we2", {31'b0, WE2}, 0);
    check("st_done_empty", {31'b0, Empty}, 1);
    check("st_mem", mem_rd(32'h7F), 32'h6000);
    drive(1'b0, 1'b1, 32'h7F, 32'h0);
    tick(); idle();
    check("ld_vld_early", {31'b0, LoadVld}, 0);
    check("ld_addr", Addr, 32'h7F);
    tick();
    check("ld_vld", {31'b0, LoadVld}, 1);
    check("ld_dat", LoadDat, 32'h6000);
    tick();
    check("ld_vld_pulse", {31'b0, LoadVld}, 0);

    // Fill: loads delay the drain so four stores are buffered at once.
    drive(1'b1, 1'b0, 32'h0, 32'h11);
    tick();
    drive(1'b0, 1'b1, 32'h50, 32'h0);
    check("fill_ld_stall", {31'b0, Stall}, 0);
    tick();
    drive(1'b1, 1'b0, 32'h1, 32'h22);
    tick();
    check("fill_ld1_vld", {31'b0, LoadVld}, 1);
    check("fill_ld1_dat", LoadDat, 32'hD050);
    drive(1'b1, 1'b0, 32'h2, 32'h33);
    tick();
    check("fill_setup_addr", Addr, 32'h0);
    check("fill_setup_we2", {31'b0, WE2}, 0);
    drive(1'b0, 1'b1, 32'h51, 32'h0);
    tick();
    check("fill_ldprio_we2", {31'b0, WE2}, 0);
    drive(1'b1, 1'b0, 32'h3, 32'h44);
    tick();
    check("fill_full", {31'b0, Full}, 1);
    check("fill_ld2_vld", {31'b0, LoadVld}, 1);
    check("fill_ld2_dat", LoadDat, 32'hD051);
    drive(1'b1, 1'b0, 32'h4, 32'h55);
    check("fill_stall_ld", {31'b0, Stall}, 1);
    tick();
    check("fill_stall_setup", {31'b0, Stall}, 1);
    check("fill_resume_addr", Addr, 32'h0);
    check("fill_resume_dat", WriDat, 32'h11);
    tick();
    check("fill_write_we2", {31'b0, WE2}, 1);
    check("fill_pop_accept", {31'b0, Stall}, 0);
    tick(); idle();
    check("fill_still_full", {31'b0, Full}, 1);
    check("fill_next_addr", Addr, 32'h1);
    check("fill_next_dat", WriDat, 32'h22);
    wait_empty("fill_drain");
    for (int i = 0; i < 5; i++) begin
      check($sformatf("fill_mem%0d", i), mem_rd(32'(i)), 32'(i + 1) * 32'h11);
      check($sformatf("fill_order%0d", i), wr_log[i + 1], 32'(i));
    end

    // Forwarding from the youngest of two buffered stores to one address.
    drive(1'b1, 1'b0, 32'h10, 32'hAAAA);
    tick();
    drive(1'b1, 1'b0, 32'h10, 32'hBBBB);
    tick();
    drive(1'b0, 1'b1, 32'h10, 32'h0);
    tick(); idle();
    check("fwd_buffered", {31'b0, Empty}, 0);
    check("fwd_ld_addr", Addr, 32'h10);
    tick();
    check("fwd_vld", {31'b0, LoadVld}, 1);
    check("fwd_dat", LoadDat, 32'hBBBB);
    tick();
    check("fwd_resume_dat", WriDat, 32'hAAAA);
    check("fwd_resume_we2", {31'b0, WE2}, 0);
    tick();
    check("fwd_write_we2", {31'b0, WE2}, 1);
    wait_empty("fwd_drain");
    check("fwd_mem", mem_rd(32'h10), 32'hBBBB);

    // Store and load together: load wins, store follows next cycle.
    drive(1'b1, 1'b1, 32'h20, 32'h1234);
    check("sl_stall", {31'b0, Stall}, 1);
    tick();
    drive(1'b1, 1'b0, 32'h20, 32'h1234);
    check("sl_store_held", {31'b0, Empty}, 1);
    check("sl_store_go", {31'b0, Stall}, 0);
    tick(); idle();
    check("sl_vld", {31'b0, LoadVld}, 1);
    check("sl_dat", LoadDat, 32'hD020);
    check("sl_store_in", {31'b0, Empty}, 0);
    wait_empty("sl_drain");
    check("sl_mem", mem_rd(32'h20), 32'h1234);

    // Out-of-range store address.
    drive(1'b1, 1'b0, 32'h80, 32'h99);
    tick(); idle();
    check("oob_addrerr", {31'b0, AddrErr}, 1);
    tick();
    check("oob_addrerr_pulse", {31'b0, AddrErr}, 0);
    wait_empty("oob_drain");

    // Reset in the middle of a WRITE.
    drive(1'b1, 1'b0, 32'h30, 32'h77);
    tick();
    drive(1'b1, 1'b0, 32'h31, 32'h88);
    tick();
    drive(1'b1, 1'b0, 32'h32, 32'h99);
    tick(); idle();
    check("rw_we2", {31'b0, WE2}, 1);
    wc = wr_cnt;
    rst = 1'b1;
    #1;
    check("rw_we2_drop", {31'b0, WE2}, 0);
    check("rw_empty", {31'b0, Empty}, 1);
    check("rw_full", {31'b0, Full}, 0);
    tick();
    rst = 1'b0;
    repeat (10) tick();
    check("rw_no_writes", 32'(wr_cnt), 32'(wc));
    check("rw_mem", mem_rd(32'h30), 32'hD030);
    check("rw_still_empty", {31'b0, Empty}, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
